idu_exu_pipe: RTL and testbench
===============================

// Module: idu_exu_pipe
// PURPOSE
//  Decode->execute pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Sits directly upstream of the ALU: it holds alu_ctr, operands and writeback tag for one
//  instruction, and presents them to the execute stage.
//  Gives full throughput with a registered in_ready, and supports a synchronous flush on
//  branch redirect.
// PARAMETERS
//  BITS  32  operand/PC width (alu_a, alu_b, pc)
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  flush        in   1     synchronous kill of all held entries
//  in_valid     in   1     decode presents an instruction
//  in_ready     out  1     pipe can accept; registered (= ~skid_valid)
//  in_alu_ctr   in   4     ALU control code
//  in_alu_a     in   BITS  operand A
//  in_alu_b     in   BITS  operand B
//  in_rd        in   5     destination register index
//  in_wen       in   1     register writeback enable
//  in_pc        in   BITS  instruction PC
//  out_valid    out  1     entry presented to execute
//  out_ready    in   1     execute consumes the entry this cycle
//  out_alu_ctr/out_alu_a/out_alu_b/out_rd/out_wen/out_pc  out  as inputs  head-entry fields
//  stall_cnt    out  32    only with EXU_PIPE_PERF_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): main_valid=0, skid_valid=0, all out_* fields = 0,
//    out_valid=0, in_ready=1.
//  - Accept when in_valid&in_ready. Transfer out when out_valid&out_ready.
//  - Latency: an accepted instruction appears on out_* the next cycle. No combinational
//    in->out path, and no combinational out_ready->in_ready path.
//  - States by {skid_valid,main_valid}:
//    EMPTY(00): accept -> FULL1, loaded into main.
//    FULL1(01): accept and drain -> FULL1, main reloaded.
//               accept only -> FULL2, incoming word goes to skid.
//               drain only -> EMPTY.
//               neither -> hold.
//    FULL2(11): in_ready=0. Drain -> FULL1 and main<=skid. No drain -> hold.
//  - Order is strictly FIFO: skid contents always go out after main.
//  - out_* fields stay stable while out_valid=1 and out_ready=0. in_valid while in_ready=0
//    is ignored, with no side effects.
//  - flush=1: next state EMPTY, regardless of in_valid/out_ready that cycle.
//    The same-cycle input is dropped and the same-cycle output is still counted as
//    consumed by execute. Data fields need not clear.
//  - Reset mid-operation drops every entry immediately. Nothing is replayed.
//  - Data flip-flops load only on accept/shift, not every cycle.
// CONFIGURATION
//  EXU_PIPE_PERF_CNT_EN defined:
//   - Adds port stall_cnt[31:0], reset to 0.
//   - Increments by 1 on each cycle with out_valid=1 and out_ready=0.
//   - Wraps 0xFFFFFFFF->0. Not cleared by flush.
//  Undefined: stall_cnt port and counter are absent. Handshake behaviour is identical.
// TESTING
//  1. Reset with in_valid=1 -> out_valid=0, in_ready=1, out_alu_a=0. After release,
//     push ctr=4'b0000, a=5, b=7 -> next cycle out_valid=1, out_alu_a=5, out_alu_b=7.
//  2. out_ready=1 constant, push 8 back-to-back (a=0..7) -> one per cycle out, in order,
//     in_ready never drops.
//  3. out_ready=0, push a=1,2,3 -> a=1 and a=2 held, in_ready=0 after 2nd accept,
//     a=3 not accepted. Raise out_ready -> out 1,2, then 3 after re-accept.
//  4. FULL2 with flush=1 and in_valid=1 (a=9) -> next cycle out_valid=0, in_ready=1.
//     a=9 never appears.
//  5. Entry held with out_ready=0 for 10 cycles, fields toggled on in_* -> out_* constant.
//     With EXU_PIPE_PERF_CNT_EN, stall_cnt=10.
//  6. rst_n pulsed low mid-stream in FULL2 -> out_valid=0 asynchronously. First output
//     after release is the first new push.

Source files
------------

// File: rtl/idu_exu_pipe.sv
// idu_exu_pipe: decode->execute pipeline register with valid/ready handshake
// and a 2-entry (main + skid) buffer. in_ready is a pure function of state
// flops, so there is no combinational out_ready->in_ready path.
// Optional feature: define EXU_PIPE_PERF_CNT_EN to add the stall_cnt port.
module idu_exu_pipe #(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctr,
  input  logic [BITS-1:0] in_alu_a,
  input  logic [BITS-1:0] in_alu_b,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic [BITS-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctr,
  output logic [BITS-1:0] out_alu_a,
  output logic [BITS-1:0] out_alu_b,
  output logic [4:0]      out_rd,
  output logic            out_wen,
`ifdef EXU_PIPE_PERF_CNT_EN
  output logic [BITS-1:0] out_pc,
  output logic [31:0]     stall_cnt
`else
  output logic [BITS-1:0] out_pc
`endif
);

  typedef struct packed {
    logic [3:0]      alu_ctr;
    logic [BITS-1:0] alu_a;
    logic [BITS-1:0] alu_b;
    logic [4:0]      rd;
    logic            wen;
    logic [BITS-1:0] pc;
  } entry_t;

  // Encoding is {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b01,
    FULL2 = 2'b11
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   accept, drain;
  logic   load_main, main_from_skid, load_skid;

  assign in_entry = '{alu_ctr: in_alu_ctr, alu_a: in_alu_a, alu_b: in_alu_b,
                      rd: in_rd, wen: in_wen, pc: in_pc};

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_alu_ctr = main_q.alu_ctr;
  assign out_alu_a   = main_q.alu_a;
  assign out_alu_b   = main_q.alu_b;
  assign out_rd      = main_q.rd;
  assign out_wen     = main_q.wen;
  assign out_pc      = main_q.pc;

  // Next-state and data-load enables; flush overrides every transition
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL1;
            load_main = 1'b1;
          end
        end
        FULL1: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = FULL2;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL2: begin
          if (drain) begin
            state_d        = FULL1;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head entry: loads only on accept into main or skid->main shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_q : in_entry;
    end
  end

  // Skid entry: catches the word accepted while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_entry;
    end
  end

`ifdef EXU_PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Stall counter: cycles where execute holds off a valid head; wraps, ignores flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idu_exu_pipe.sv
// tb_idu_exu_pipe: directed scoreboard bench for idu_exu_pipe.
// Occupancy (and thus expected out_valid/in_ready) is modelled by the queue.
module tb_idu_exu_pipe;

  localparam int unsigned BITS = 32;
  localparam int unsigned EW   = 4 + 3 * BITS + 5 + 1;

  logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]      in_alu_ctr, out_alu_ctr;
  logic [BITS-1:0] in_alu_a, in_alu_b, in_pc, out_alu_a, out_alu_b, out_pc;
  logic [4:0]      in_rd, out_rd;
  logic            in_wen, out_wen;
`ifdef EXU_PIPE_PERF_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [EW-1:0] q[$];

  idu_exu_pipe #(.BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctr(in_alu_ctr), .in_alu_a(in_alu_a), .in_alu_b(in_alu_b),
    .in_rd(in_rd), .in_wen(in_wen), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctr(out_alu_ctr), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_rd(out_rd), .out_wen(out_wen),
`ifdef EXU_PIPE_PERF_CNT_EN
    .out_pc(out_pc),
    .stall_cnt(stall_cnt)
`else
    .out_pc(out_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] in_word();
    return {in_alu_ctr, in_alu_a, in_alu_b, in_rd, in_wen, in_pc};
  endfunction

  function automatic logic [EW-1:0] out_word();
    return {out_alu_ctr, out_alu_a, out_alu_b, out_rd, out_wen, out_pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set payload; other fields derived from a so each word is distinct
  task automatic drive(input logic v, input logic [BITS-1:0] a);
    in_valid   = v;
    in_alu_a   = a;
    in_alu_b   = a ^ 32'hA5A5_0000;
    in_alu_ctr = a[3:0] ^ 4'h6;
    in_rd      = a[4:0] + 5'd3;
    in_wen     = a[0];
    in_pc      = 32'h8000_0000 + (a << 2);
  endtask

  // Called at negedge with inputs already set: check outputs, update model, advance a cycle
  task automatic tick(output bit acc);
    bit mv, mr;
    mv = (q.size() > 0);
    mr = (q.size() < 2);
    chk("out_valid", out_valid, mv);
    chk("in_ready", in_ready, mr);
    if (mv) chk("head", out_word(), q[0]);
    acc = in_valid && mr && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (mv && out_ready) void'(q.pop_front());
      if (acc) q.push_back(in_word());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold in_valid with word a until the model says it was accepted (bounded)
  task automatic push(input logic [BITS-1:0] a);
    bit acc;
    int unsigned n;
    n = 0;
    drive(1'b1, a);
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("push_timeout", 1'b0, 1'b1);
    drive(1'b0, a);
  endtask

  task automatic drain_all();
    bit acc;
    int unsigned n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 50) begin
      tick(acc);
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 1'b0, 1'b1);
    tick(acc);
  endtask

  initial begin
    bit acc;
`ifdef EXU_PIPE_PERF_CNT_EN
    logic [31:0] c0;
`endif
    // 1: reset with in_valid high
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'd99);
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_alu_a", out_alu_a, 32'd0);
    chk("rst_out_word", out_word(), '0);
`ifdef EXU_PIPE_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd0);
    tick(acc);
    drive(1'b1, 32'd5);
    in_alu_ctr = 4'b0000; in_alu_b = 32'd7;
    tick(acc);
    drive(1'b0, 32'd0);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_alu_a", out_alu_a, 32'd5);
    chk("t1_alu_b", out_alu_b, 32'd7);
    chk("t1_alu_ctr", out_alu_ctr, 4'b0000);
    drain_all();

    // 2: streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i);
      tick(acc);
      chk("t2_accept", acc, 1'b1);
    end
    drive(1'b0, 32'd0);
    drain_all();

    // 3: backpressure fills main+skid, third word waits
    out_ready = 1'b0;
    drive(1'b1, 32'd1); tick(acc);
    drive(1'b1, 32'd2); tick(acc);
    chk("t3_in_ready_low", in_ready, 1'b0);
    drive(1'b1, 32'd3); tick(acc); tick(acc);
    chk("t3_a3_rejected", acc, 1'b0);
    chk("t3_held_a", out_alu_a, 32'd1);
    out_ready = 1'b1;
    push(32'd3);
    drain_all();

    // 4: flush in FULL2 with a new word offered
    out_ready = 1'b0;
    push(32'd10);
    push(32'd11);
    flush = 1'b1;
    drive(1'b1, 32'd9);
    tick(acc);
    flush = 1'b0;
    drive(1'b0, 32'd0);
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    push(32'd12);
    drain_all();

    // 5: head stable for 10 stalled cycles while inputs toggle
    out_ready = 1'b0;
    push(32'd20);
`ifdef EXU_PIPE_PERF_CNT_EN
    c0 = stall_cnt;
`endif
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'hFFFF_0000 + i * 32'h1357);
      tick(acc);
      chk("t5_stable_a", out_alu_a, 32'd20);
    end
`ifdef EXU_PIPE_PERF_CNT_EN
    chk("t5_stall_cnt", stall_cnt - c0, 32'd10);
`endif
    drain_all();

    // 6: async reset in FULL2, then a fresh push is first out
    out_ready = 1'b0;
    push(32'd30);
    push(32'd31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_ready", in_ready, 1'b1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'd40);
    chk("t6_first_a", out_alu_a, 32'd40);
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
